// File: rtl/l1_ld_mem_arb_if.sv
// Bundle of the LU/RF requester handshakes and the single-port L1 data array bus.
// slave: the arbiter side; master: requesters plus the memory they share.
interface l1_ld_mem_arb_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 10
);
  logic             mem_ready;
  logic             lu_req;
  logic             lu_we;
  logic [AW-1:0]    lu_addr;
  logic [WIDTH-1:0] lu_wdata;
  logic             lu_gnt;
  logic             lu_rvalid;
  logic [WIDTH-1:0] lu_rdata;
  logic             rf_req;
  logic [AW-1:0]    rf_addr;
  logic [WIDTH-1:0] rf_wdata;
  logic             rf_gnt;
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  mem_ready,
    input  lu_req, lu_we, lu_addr, lu_wdata,
    output lu_gnt, lu_rvalid, lu_rdata,
    input  rf_req, rf_addr, rf_wdata,
    output rf_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output mem_ready,
    output lu_req, lu_we, lu_addr, lu_wdata,
    input  lu_gnt, lu_rvalid, lu_rdata,
    output rf_req, rf_addr, rf_wdata,
    input  rf_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/l1_ld_mem_arb.sv
// Arbiter in front of the single-port L1 data array: refill writes beat core lookups
// unless the lookup port has lost STARVE_MAX times in a row; LU reads return one cycle later.
module l1_ld_mem_arb #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              CLK,
  input logic              RST_N,
  l1_ld_mem_arb_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             rd_pend_q, rd_pend_d;

  logic             arb_ok;
  logic             lu_win;
  logic             lu_gnt;
  logic             rf_gnt;
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StInit;
      starve_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // The array is only usable while its clearing sweep reports done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (bus.mem_ready)  state_d = StRun;
      StRun:   if (!bus.mem_ready) state_d = StInit;
      default: state_d = StInit;
    endcase
  end

  // A cycle with mem_ready low grants nothing, even before the FSM leaves StRun.
  assign arb_ok = (state_q == StRun) && bus.mem_ready;

  always_comb begin
    lu_win = (starve_q == StarveMax);
    lu_gnt = arb_ok && bus.lu_req && (!bus.rf_req || lu_win);
    rf_gnt = arb_ok && bus.rf_req && !lu_gnt;
  end

  always_comb begin
    starve_d = starve_q;
    if (lu_gnt || !bus.lu_req) begin
      starve_d = '0;
    end else if (rf_gnt && (starve_q != StarveMax)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rf_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = bus.rf_addr;
      mem_wdata = bus.rf_wdata;
    end else if (lu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.lu_we;
      mem_addr  = bus.lu_addr;
      mem_wdata = bus.lu_wdata;
    end
  end

  assign rd_pend_d = lu_gnt && !bus.lu_we;

  assign bus.lu_gnt    = lu_gnt;
  assign bus.rf_gnt    = rf_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  // A read in flight when the array drops ready is abandoned, so its return is masked.
  assign bus.lu_rvalid = rd_pend_q && bus.mem_ready;
  assign bus.lu_rdata  = bus.mem_rdata;

endmodule
